lut_layer_scheduler: RTL and testbench

Time-multiplexed evaluator for one layer of fan-in-6 truth-table neurons. A single shared 64-entry lookup datapath is sequenced across NUM_NEURONS virtual neurons, one neuron per cycle. Per-neuron truth tables and input connectivity are loaded through a configuration port. The block sits between successive layer stages and uses valid/ready on both its input feature vector and its output vector.

---
 rtl/lut_layer_scheduler_if.sv | 32 +++
 rtl/lut_layer_scheduler.sv | 130 +++++++++++++
 tb/tb_lut_layer_scheduler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_layer_scheduler_if.sv
// rtl/lut_layer_scheduler_if.sv - input/output/config handshake bundle for lut_layer_scheduler
interface lut_layer_scheduler_if #(
  parameter int NUM_NEURONS = 16,
  parameter int IN_W        = 64
);
  localparam int NW = $clog2(NUM_NEURONS);

  logic                   in_valid;
  logic                   in_ready;
  logic [IN_W-1:0]        in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_NEURONS-1:0] out_data;
  logic                   cfg_we;
  logic                   cfg_ready;
  logic                   cfg_sel;
  logic [NW-1:0]          cfg_neuron;
  logic [2:0]             cfg_slot;
  logic [63:0]            cfg_wdata;

  modport master (
    output in_valid, in_data, out_ready,
    output cfg_we, cfg_sel, cfg_neuron, cfg_slot, cfg_wdata,
    input  in_ready, out_valid, out_data, cfg_ready
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    input  cfg_we, cfg_sel, cfg_neuron, cfg_slot, cfg_wdata,
    output in_ready, out_valid, out_data, cfg_ready
  );
endinterface

// File: rtl/lut_layer_scheduler.sv
// rtl/lut_layer_scheduler.sv - time-multiplexed fan-in-6 LUT layer evaluator (optional LUT_SCHED_PERF_EN counters)
module lut_layer_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int IN_W        = 64,
  parameter int IDX_W       = $clog2(IN_W)
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef LUT_SCHED_PERF_EN
  output logic [31:0]            perf_infer,
  output logic [31:0]            perf_stall,
`endif
  lut_layer_scheduler_if.slave   bus
);

  localparam int NW   = $clog2(NUM_NEURONS);
  localparam int PADW = 1 << IDX_W;
  localparam logic [NW-1:0] K_LAST = NW'(NUM_NEURONS - 1);
  localparam logic [NW:0]   N_LIM  = (NW + 1)'(NUM_NEURONS);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [IN_W-1:0]        vec_r;
  logic [NW-1:0]          k_r;
  logic [NUM_NEURONS-1:0] res_r;
  logic [63:0]            tbl_r  [NUM_NEURONS];
  logic [IDX_W-1:0]       conn_r [NUM_NEURONS][6];

  logic                   idle;
  logic                   accept;
  logic                   last_k;
  logic                   cfg_hit;
  logic [PADW-1:0]        vec_pad;
  logic [5:0]             addr;
  logic                   lut_bit;

  // Reset wins over any handshake, so ready is held low while rst is high.
  assign idle          = (state_q == IDLE);
  assign bus.in_ready  = idle && !rst;
  assign bus.cfg_ready = idle && !rst;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = res_r;

  assign accept  = bus.in_valid && idle;
  assign last_k  = (k_r == K_LAST);
  assign cfg_hit = bus.cfg_we && idle && ({1'b0, bus.cfg_neuron} < N_LIM);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode: IDLE -> EVAL on handshake, EVAL -> HOLD after last neuron, HOLD -> IDLE on accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EVAL;
      EVAL:    if (last_k) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lookup path: gather six selected input bits into an address, index the current neuron's table.
  // Indices past IN_W land in the zero padding and therefore read as 0.
  always_comb begin
    vec_pad           = '0;
    vec_pad[IN_W-1:0] = vec_r;
    addr              = '0;
    for (int s = 0; s < 6; s++) begin
      addr[s] = vec_pad[conn_r[k_r][s]];
    end
    lut_bit = tbl_r[k_r][addr];
  end

  // Configuration storage; a write in the handshake cycle lands before the first EVAL cycle reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        tbl_r[n] <= '0;
        for (int s = 0; s < 6; s++) begin
          conn_r[n][s] <= '0;
        end
      end
    end else if (cfg_hit) begin
      if (!bus.cfg_sel) begin
        tbl_r[bus.cfg_neuron] <= bus.cfg_wdata;
      end else if (bus.cfg_slot < 3'd6) begin
        conn_r[bus.cfg_neuron][bus.cfg_slot] <= bus.cfg_wdata[IDX_W-1:0];
      end
    end
  end

  // Datapath: latch the input vector, then step one neuron per cycle into res_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_r <= '0;
      k_r   <= '0;
      res_r <= '0;
    end else begin
      if (accept) begin
        vec_r <= bus.in_data;
        k_r   <= '0;
      end else if (state_q == EVAL) begin
        res_r[k_r] <= lut_bit;
        k_r        <= last_k ? '0 : k_r + 1'b1;
      end
    end
  end

`ifdef LUT_SCHED_PERF_EN
  // Throughput counters: completed inferences (wrapping) and backpressured HOLD cycles (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_infer <= '0;
      perf_stall <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        perf_infer <= perf_infer + 32'd1;
      end
      if (bus.out_valid && !bus.out_ready && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// tb/tb_lut_layer_scheduler.sv - self-checking bench for lut_layer_scheduler against a truth-table model
module tb_lut_layer_scheduler;
  localparam int NN  = 16;
  localparam int IW  = 48;
  localparam int IDX = $clog2(IW);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_layer_scheduler_if #(.NUM_NEURONS(NN), .IN_W(IW)) bus ();

`ifdef LUT_SCHED_PERF_EN
  logic [31:0] perf_infer, perf_stall;
`endif

  lut_layer_scheduler #(.NUM_NEURONS(NN), .IN_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef LUT_SCHED_PERF_EN
    .perf_infer (perf_infer),
    .perf_stall (perf_stall),
`endif
    .bus        (bus)
  );

  logic [63:0] m_tbl  [NN];
  int          m_conn [NN][6];
  int          m_infer, m_stall;
  int          total, bad;

  function automatic logic [NN-1:0] predict(input logic [IW-1:0] v);
    logic [NN-1:0] r;
    int a, idx;
    r = '0;
    for (int k = 0; k < NN; k++) begin
      a = 0;
      for (int s = 0; s < 6; s++) begin
        idx = m_conn[k][s];
        if (idx < IW && v[idx]) a = a + (1 << s);
      end
      r[k] = m_tbl[k][a];
    end
    return r;
  endfunction

  task automatic model_cfg(input logic sel, input int neuron, input int slot, input logic [63:0] wd);
    if (neuron < NN) begin
      if (!sel) m_tbl[neuron] = wd;
      else if (slot < 6) m_conn[neuron][slot] = int'(wd[IDX-1:0]);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < NN; n++) begin
      m_tbl[n] = '0;
      for (int s = 0; s < 6; s++) m_conn[n][s] = 0;
    end
    m_infer = 0;
    m_stall = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] rand_vec();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[IW-1:0];
  endfunction

  task automatic cfg_write(input logic sel, input int neuron, input int slot, input logic [63:0] wd);
    bus.cfg_sel    = sel;
    bus.cfg_neuron = neuron[$clog2(NN)-1:0];
    bus.cfg_slot   = slot[2:0];
    bus.cfg_wdata  = wd;
    bus.cfg_we     = 1'b1;
    step();
    bus.cfg_we     = 1'b0;
    model_cfg(sel, neuron, slot, wd);
  endtask

  task automatic wait_hold(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic finish_hold();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    m_infer++;
    chk("in_ready_after_hold", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_infer(input string tag, input logic [IW-1:0] v, output logic [NN-1:0] got);
    logic [NN-1:0] exp;
    int n;
    exp = predict(v);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_hold(n);
    chk({tag, "_latency"}, 64'(n), 64'(NN));
    got = bus.out_data;
    chk({tag, "_out_data"}, 64'(got), 64'(exp));
    finish_hold();
  endtask

  logic [NN-1:0] got, held;
  logic [IW-1:0] v;
  logic [63:0]   wd;
  int            n, seen;

  initial begin
    total = 0; bad = 0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_neuron = '0;
    bus.cfg_slot = '0; bus.cfg_wdata = '0;
    model_clear();

    // Reset held with in_valid high.
    rst = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    run_infer("zero_tables", rand_vec(), got);
    chk("zero_tables_const", 64'(got), 64'd0);

    // Basic: neuron 3 is a 6-input AND of bits 0..5.
    cfg_write(1'b0, 3, 0, 64'h8000_0000_0000_0000);
    for (int s = 0; s < 6; s++) cfg_write(1'b1, 3, s, 64'(s));
    v = rand_vec();
    v[5:0] = 6'h3F;
    run_infer("basic", v, got);
    chk("basic_const", 64'(got), 64'h0008);

    // Out-of-range index reads 0; in-range index 7 selects bit 7.
    cfg_write(1'b0, 0, 0, 64'h2);
    cfg_write(1'b1, 0, 0, 64'(IW));
    v = '1;
    run_infer("oor", v, got);
    chk("oor_bit0", 64'(got[0]), 64'd0);
    cfg_write(1'b1, 0, 0, 64'd7);
    v = rand_vec();
    v[7] = 1'b1;
    v[0] = 1'b0;
    run_infer("idx7", v, got);
    chk("idx7_bit0", 64'(got[0]), 64'd1);

    // Slot 6/7 writes are ignored.
    cfg_write(1'b1, 0, 6, 64'd9);
    cfg_write(1'b1, 0, 7, 64'd9);
    run_infer("slot67", rand_vec(), got);

    // Backpressure: 10 stalled HOLD cycles with an ignored config pulse.
    v = rand_vec();
    bus.in_data = v;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_hold(n);
    chk("bp_latency", 64'(n), 64'(NN));
    held = bus.out_data;
    chk("bp_out_data", 64'(held), 64'(predict(v)));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.cfg_sel = 1'b0; bus.cfg_neuron = 1; bus.cfg_wdata = '1; bus.cfg_we = 1'b1;
      end
      step();
      bus.cfg_we = 1'b0;
      m_stall++;
      chk("bp_stable", 64'(bus.out_data), 64'(held));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    chk("bp_cfg_ready", 64'(bus.cfg_ready), 64'd0);
`ifdef LUT_SCHED_PERF_EN
    chk("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
    finish_hold();
`ifdef LUT_SCHED_PERF_EN
    chk("perf_infer", 64'(perf_infer), 64'(m_infer));
`endif
    v = rand_vec();
    v[5:0] = 6'h00;
    run_infer("bp_cfg_ignored", v, got);
    chk("bp_cfg_ignored_bit1", 64'(got[1]), 64'd0);

    // Same-cycle config write and input handshake.
    v = rand_vec();
    bus.cfg_sel = 1'b0; bus.cfg_neuron = 0; bus.cfg_wdata = '1; bus.cfg_we = 1'b1;
    bus.in_data = v; bus.in_valid = 1'b1;
    step();
    bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
    model_cfg(1'b0, 0, 0, '1);
    wait_hold(n);
    chk("same_cycle_latency", 64'(n), 64'(NN));
    chk("same_cycle_out", 64'(bus.out_data), 64'(predict(v)));
    chk("same_cycle_bit0", 64'(bus.out_data[0]), 64'd1);
    finish_hold();

    // Randomized configuration and inputs.
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 5; w++) begin
        wd = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) begin
          cfg_write(1'b1, $urandom_range(0, NN - 1), $urandom_range(0, 7), 64'($urandom_range(0, 63)));
        end else begin
          cfg_write(1'b0, $urandom_range(0, NN - 1), 0, wd);
        end
      end
      run_infer("random", rand_vec(), got);
    end
`ifdef LUT_SCHED_PERF_EN
    chk("perf_infer_random", 64'(perf_infer), 64'(m_infer));
    chk("perf_stall_random", 64'(perf_stall), 64'(m_stall));
`endif

    // Mid-EVAL reset at k=5.
    bus.in_data = rand_vec();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);
`ifdef LUT_SCHED_PERF_EN
    chk("midrst_perf_infer", 64'(perf_infer), 64'd0);
    chk("midrst_perf_stall", 64'(perf_stall), 64'd0);
`endif
    run_infer("midrst_cleared", rand_vec(), got);
    chk("midrst_cleared_const", 64'(got), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
